// File: rtl/id_exe_stage_pkg.sv
// ---------------------------------------------------------------------------
// id_exe_stage_pkg
// Shared definitions for the decode->execute stage register.
//   - default operand/instruction widths
//   - slot payload width helper: a slot is {valid, inst, r}; the valid bit
//     lives in its own flop, so slot_w() returns the width of {inst, r}
//   - source selector for the main slot's next contents
// ---------------------------------------------------------------------------
package id_exe_stage_pkg;

    localparam int unsigned DW_DEF   = 32;
    localparam int unsigned IW_DEF   = 32;
    localparam int unsigned NREG_DEF = 2;
    localparam int unsigned CNTW_DEF = 16;

    // Payload width of one slot, {inst, r}; the valid bit is held separately.
    function automatic int unsigned slot_w(input int unsigned nreg,
                                           input int unsigned dw,
                                           input int unsigned iw);
        return iw + nreg * dw;
    endfunction

    // Where the main slot takes its next value from on a clock edge.
    typedef enum logic [1:0] {
        M_HOLD      = 2'd0,
        M_FROM_SKID = 2'd1,
        M_FROM_IN   = 2'd2,
        M_CLEAR     = 2'd3
    } m_src_e;

endpackage

// File: rtl/id_exe_stage_if.sv
// ---------------------------------------------------------------------------
// id_exe_stage_if
// Handshake bundle around the ID->EXE stage register.
//   upstream   : in_valid, in_ready, in_r, in_inst
//   downstream : out_valid, out_ready, out_r, out_inst
//   control    : flush
//   status     : stall_cnt
// Modports: slave = the stage itself, master = the environment driving it.
// ---------------------------------------------------------------------------
interface id_exe_stage_if
    import id_exe_stage_pkg::*;
#(
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned IW   = IW_DEF,
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned CNTW = CNTW_DEF
) ();

    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [NREG*DW-1:0]   in_r;
    logic [IW-1:0]        in_inst;
    logic                 out_valid;
    logic                 out_ready;
    logic [NREG*DW-1:0]   out_r;
    logic [IW-1:0]        out_inst;
    logic [CNTW-1:0]      stall_cnt;

    modport slave (
        input  flush, in_valid, in_r, in_inst, out_ready,
        output in_ready, out_valid, out_r, out_inst, stall_cnt
    );

    modport master (
        output flush, in_valid, in_r, in_inst, out_ready,
        input  in_ready, out_valid, out_r, out_inst, stall_cnt
    );

endinterface

// File: rtl/id_exe_stage_slot.sv
// ---------------------------------------------------------------------------
// id_exe_stage_slot
// One pipeline slot: a valid flag plus a payload register.
//   clk, rst  : clock, asynchronous active-high reset
//   i_load    : capture i_data and set valid
//   i_clear   : drop valid (wins over i_load); payload keeps its stale value
//   i_data    : payload to capture
//   o_valid   : slot occupied
//   o_data    : stored payload
// ---------------------------------------------------------------------------
module id_exe_stage_slot #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end
    end

    // NOTE: the payload is reset too, because out_r/out_inst must read zero
    // straight after reset; a clear only drops valid and leaves data stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (i_load && !i_clear) begin
            r_data <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/id_exe_stage.sv
// ---------------------------------------------------------------------------
// id_exe_stage
// Decode->execute pipeline register with valid/ready handshake, a two-entry
// skid buffer (main slot M + skid slot S), synchronous flush and a
// saturating stall-cycle counter.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : id_exe_stage_if.slave
//              in_valid/in_ready/in_r/in_inst    upstream (ID)
//              out_valid/out_ready/out_r/out_inst downstream (EXE), from M
//              flush                              kill all held entries
//              stall_cnt                          cycles with out_valid & !out_ready
// in_ready is a flop (= !S.valid), so there is no combinational path from
// out_ready back to in_ready.
// ---------------------------------------------------------------------------
module id_exe_stage
    import id_exe_stage_pkg::*;
#(
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned IW   = IW_DEF,
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned CNTW = CNTW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    id_exe_stage_if.slave  bus
);

    localparam int unsigned SW = slot_w(NREG, DW, IW);

    logic          w_m_valid;
    logic          w_s_valid;
    logic [SW-1:0] w_m_data;
    logic [SW-1:0] w_s_data;
    logic [SW-1:0] w_in_data;
    logic [SW-1:0] w_m_d;
    logic          w_in_xfer;
    logic          w_m_free;
    logic          w_m_load;
    logic          w_m_clear;
    logic          w_s_load;
    logic          w_s_clear;
    logic          w_s_valid_nxt;
    m_src_e        w_m_src;

    logic            r_in_ready;
    logic [CNTW-1:0] r_stall_cnt;

    assign w_in_data = {bus.in_inst, bus.in_r};
    assign w_in_xfer = bus.in_valid & r_in_ready;
    // M can take a new entry this edge: it is empty or its entry is leaving.
    assign w_m_free  = !w_m_valid | bus.out_ready;

    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        w_m_src = M_HOLD;
        if (bus.flush) begin
            w_m_src = M_CLEAR;
        end else if (w_m_free) begin
            // S is older than anything on in_*, so it always goes first.
            if (w_s_valid)      w_m_src = M_FROM_SKID;
            else if (w_in_xfer) w_m_src = M_FROM_IN;
            else                w_m_src = M_CLEAR;
        end
    end

    assign w_m_load  = (w_m_src == M_FROM_SKID) || (w_m_src == M_FROM_IN);
    assign w_m_clear = (w_m_src == M_CLEAR);
    assign w_m_d     = (w_m_src == M_FROM_SKID) ? w_s_data : w_in_data;

    // S only fills while M is held. When S is occupied in_ready is low, so
    // draining S into M can never coincide with an accepted new entry.
    assign w_s_load      = !bus.flush & w_in_xfer & !w_m_free;
    assign w_s_clear     = bus.flush | w_m_free;
    assign w_s_valid_nxt = w_s_load | (w_s_valid & !w_s_clear);

    id_exe_stage_slot #(.W(SW)) u_main (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_m_load),
        .i_clear (w_m_clear),
        .i_data  (w_m_d),
        .o_valid (w_m_valid),
        .o_data  (w_m_data)
    );

    id_exe_stage_slot #(.W(SW)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_s_load),
        .i_clear (w_s_clear),
        .i_data  (w_in_data),
        .o_valid (w_s_valid),
        .o_data  (w_s_data)
    );

    // in_ready mirrors the next state of S, registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_in_ready <= 1'b1;
        else     r_in_ready <= !w_s_valid_nxt;
    end

    // Saturating stall counter; flush does not clear it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_m_valid && !bus.out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = w_m_valid;
    assign {bus.out_inst, bus.out_r} = w_m_data;
    assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_id_exe_stage.sv
// ---------------------------------------------------------------------------
// tb_id_exe_stage
// Two stage instances share one stimulus stream:
//   dut_a : DW=32, IW=32, NREG=2, CNTW=16
//   dut_b : DW=8,  IW=32, NREG=3, CNTW=4
// Both see the same handshakes, so one reference model -- a FIFO of at most
// two entries plus an unbounded stall count -- predicts both; each instance
// sees its own width slice of the data and its own saturation limit.
// ---------------------------------------------------------------------------
module tb_id_exe_stage;

    typedef struct packed {
        logic [95:0] r;
        logic [31:0] inst;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic        flush;
    logic [95:0] in_r;
    logic [31:0] in_inst;

    int unsigned n_chk;
    int unsigned n_err;

    // Reference model state.
    ent_t        mq[$];
    int unsigned m_stall;
    int unsigned m_sz;

    id_exe_stage_if #(.DW(32), .IW(32), .NREG(2), .CNTW(16)) ifa ();
    id_exe_stage_if #(.DW(8),  .IW(32), .NREG(3), .CNTW(4))  ifb ();

    assign ifa.in_valid  = in_valid;
    assign ifa.out_ready = out_ready;
    assign ifa.flush     = flush;
    assign ifa.in_r      = in_r[63:0];
    assign ifa.in_inst   = in_inst;

    assign ifb.in_valid  = in_valid;
    assign ifb.out_ready = out_ready;
    assign ifb.flush     = flush;
    assign ifb.in_r      = in_r[23:0];
    assign ifb.in_inst   = in_inst;

    id_exe_stage #(.DW(32), .IW(32), .NREG(2), .CNTW(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    id_exe_stage #(.DW(8), .IW(32), .NREG(3), .CNTW(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned sat(input int unsigned c, input int unsigned lim);
        return (c > lim) ? lim : c;
    endfunction

    // Model: a stage holding up to two entries in order. Accepts when it
    // holds fewer than two, presents the oldest, counts stalled cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_stall = 0;
        end else begin
            m_sz = mq.size();
            if (m_sz > 0 && !out_ready) m_stall++;
            if (flush) begin
                mq.delete();
            end else begin
                if (m_sz > 0 && out_ready) void'(mq.pop_front());
                if (in_valid && m_sz < 2) mq.push_back('{r: in_r, inst: in_inst});
            end
        end
    end

    // Compare every cycle, half a period after the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("a_out_valid", ifa.out_valid, mq.size() != 0);
            check("b_out_valid", ifb.out_valid, mq.size() != 0);
            check("a_in_ready",  ifa.in_ready,  mq.size() < 2);
            check("b_in_ready",  ifb.in_ready,  mq.size() < 2);
            check("a_stall_cnt", ifa.stall_cnt, sat(m_stall, 65535));
            check("b_stall_cnt", ifb.stall_cnt, sat(m_stall, 15));
            if (mq.size() != 0) begin
                check("a_out_inst", ifa.out_inst, mq[0].inst);
                check("b_out_inst", ifb.out_inst, mq[0].inst);
                check("a_out_r",    ifa.out_r,    mq[0].r[63:0]);
                check("b_out_r",    ifb.out_r,    mq[0].r[23:0]);
            end
        end
    end

    // Drive one cycle of inputs, then return 1 time unit after the edge.
    task automatic step(input logic v, input logic rdy, input logic fl,
                        input logic [31:0] inst, input logic [95:0] r);
        in_valid  = v;
        out_ready = rdy;
        flush     = fl;
        in_inst   = inst;
        in_r      = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        in_inst   = '0;
        in_r      = '0;
        #11;
        rst = 1'b0;

        // T1: fill M and S, then reset between edges.
        step(1'b1, 1'b0, 1'b0, 32'h1, 96'h11);
        step(1'b1, 1'b0, 1'b0, 32'h2, 96'h22);
        check("t1_full_in_ready", ifa.in_ready, 1'b0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("t1_a_out_valid", ifa.out_valid, 1'b0);
        check("t1_b_out_valid", ifb.out_valid, 1'b0);
        check("t1_a_in_ready",  ifa.in_ready,  1'b1);
        check("t1_b_in_ready",  ifb.in_ready,  1'b1);
        check("t1_a_stall",     ifa.stall_cnt, 16'd0);
        check("t1_a_out_inst",  ifa.out_inst,  32'd0);
        check("t1_a_out_r",     ifa.out_r,     64'd0);
        check("t1_b_out_r",     ifb.out_r,     24'd0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // T2: streaming at full rate, one-cycle latency.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'(i), 96'(i * 3));
            check("t2_out_valid", ifa.out_valid, 1'b1);
            check("t2_out_inst",  ifa.out_inst,  32'(i));
            check("t2_out_r0",    ifa.out_r[31:0], 32'(i * 3));
        end
        step(1'b0, 1'b1, 1'b0, '0, '0);
        check("t2_drained", ifa.out_valid, 1'b0);

        // T3: skid fill while held, then drain in order.
        step(1'b1, 1'b1, 1'b0, 32'hA, 96'hA0);
        step(1'b1, 1'b0, 1'b0, 32'hB, 96'hB0);
        check("t3_in_ready_low", ifa.in_ready,  1'b0);
        check("t3_head_a",       ifa.out_inst,  32'hA);
        check("t3_stall_1",      ifa.stall_cnt, 16'd1);
        step(1'b0, 1'b0, 1'b0, '0, '0);
        check("t3_stall_2",      ifa.stall_cnt, 16'd2);
        step(1'b0, 1'b1, 1'b0, '0, '0);
        check("t3_head_b",       ifa.out_inst,  32'hB);
        check("t3_in_ready_up",  ifa.in_ready,  1'b1);
        step(1'b0, 1'b1, 1'b0, '0, '0);
        check("t3_empty",        ifa.out_valid, 1'b0);

        // T4: flush beats a simultaneous push.
        step(1'b1, 1'b0, 1'b0, 32'hC, 96'hC0);
        step(1'b1, 1'b0, 1'b0, 32'hD, 96'hD0);
        step(1'b1, 1'b0, 1'b1, 32'hE, 96'hE0);
        check("t4_out_valid", ifa.out_valid, 1'b0);
        check("t4_in_ready",  ifa.in_ready,  1'b1);
        check("t4_a_stall",   ifa.stall_cnt, 16'd4);
        check("t4_b_stall",   ifb.stall_cnt, 4'd4);
        step(1'b0, 1'b1, 1'b0, '0, '0);
        check("t4_no_e", ifa.out_valid, 1'b0);

        // T5: counter saturation on the 4-bit instance.
        step(1'b1, 1'b0, 1'b0, 32'hF, 96'hF0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, '0, '0);
        check("t5_b_sat",   ifb.stall_cnt, 4'd15);
        check("t5_a_count", ifa.stall_cnt, 16'd24);
        step(1'b0, 1'b0, 1'b0, '0, '0);
        check("t5_b_stable", ifb.stall_cnt, 4'd15);
        check("t5_a_count2", ifa.stall_cnt, 16'd25);
        step(1'b0, 1'b1, 1'b0, '0, '0);

        // T6: operand packing on the NREG=3, DW=8 instance.
        step(1'b1, 1'b1, 1'b0, 32'h77, 96'h12345678_9abcdef0_ff332211);
        check("t6_b_out_r", ifb.out_r,        24'h332211);
        check("t6_b_op2",   ifb.out_r[23:16], 8'h33);
        check("t6_a_out_r", ifa.out_r,        64'h9abcdef0_ff332211);
        step(1'b0, 1'b1, 1'b0, '0, '0);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 19) == 0,
                 $urandom,
                 {$urandom, $urandom, $urandom});
        end
        step(1'b0, 1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b1, 1'b0, '0, '0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
